// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver. Recovers 1-start / DATA_BITS /
// optional parity / STOP_BITS frames from an asynchronous serial line and
// presents each word with a one-cycle valid pulse and parity/framing flags.
module uart_rx #(
  parameter int   DATA_BITS   = 8,
  parameter logic PARITY_EN   = 1'b1,
  parameter logic PARITY_TYPE = 1'b0,
  parameter int   STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_16x,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_BREAK  = 3'd6
  } state_e;

  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_rec_q, perr_rec_d;
  logic                 ferr_rec_q, ferr_rec_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 ferr_now;
  logic                 complete;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state and datapath decisions; nothing but the synchronizer moves between ticks.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_rec_d   = perr_rec_q;
    ferr_rec_d   = ferr_rec_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    ferr_now     = ferr_rec_q;
    complete     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick_16x && !rx_s_q) begin
          state_d    = S_START;
          tick_cnt_d = 4'd0;
          perr_rec_d = 1'b0;
          ferr_rec_d = 1'b0;
        end
      end
      S_START: begin
        if (tick_16x) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          // Centre of the start bit: a high line here was only a glitch.
          if (tick_cnt_q == 4'd7) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_DATA;
              tick_cnt_d = 4'd0;
              bit_cnt_d  = 4'd0;
            end
          end
        end
      end
      S_DATA: begin
        if (tick_16x) begin
          // 4-bit counter wraps 15 -> 0, which restarts the next bit period.
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = PARITY_EN ? S_PARITY : S_STOP1;
            end
          end
        end
      end
      S_PARITY: begin
        if (tick_16x) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            perr_rec_d = rx_s_q != (PARITY_TYPE ? ~^shift_q : ^shift_q);
            state_d    = S_STOP1;
          end
        end
      end
      S_STOP1: begin
        if (tick_16x) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            ferr_now   = ferr_rec_q | ~rx_s_q;
            ferr_rec_d = ferr_now;
            // A bad first stop bit ends the frame now so the break detector takes over.
            if (STOP_BITS == 2 && !ferr_now) begin
              state_d = S_STOP2;
            end else begin
              complete = 1'b1;
            end
          end
        end
      end
      S_STOP2: begin
        if (tick_16x) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            ferr_now   = ferr_rec_q | ~rx_s_q;
            ferr_rec_d = ferr_now;
            complete   = 1'b1;
          end
        end
      end
      S_BREAK: begin
        // Hold here while the line stays low so a break yields a single frame.
        if (tick_16x && rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion lands at the stop-bit centre, leaving half a bit to catch the next start.
    if (complete) begin
      rx_data_d    = shift_q;
      parity_err_d = PARITY_EN & perr_rec_q;
      frame_err_d  = ferr_now;
      rx_valid_d   = 1'b1;
      tick_cnt_d   = 4'd0;
      state_d      = ferr_now ? S_BREAK : S_IDLE;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      perr_rec_q   <= 1'b0;
      ferr_rec_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_rec_q   <= perr_rec_d;
      ferr_rec_q   <= ferr_rec_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames driven onto two receivers,
// one 8E1 (A) and one 8N2 (B). Expected words and flags come from the frame
// contents the bench chose, not from the receiver's internals.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, perr_a, ferr_a, busy_a;
  logic       valid_b, perr_b, ferr_b, busy_b;

  int checks = 0;
  int errors = 0;
  int busy_cyc_b = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_TYPE(1'b0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick), .rx_in(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .parity_err(perr_a),
    .frame_err(ferr_a), .rx_busy(busy_a)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_TYPE(1'b1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick), .rx_in(rx_b),
    .rx_data(data_b), .rx_valid(valid_b), .parity_err(perr_b),
    .frame_err(ferr_b), .rx_busy(busy_b)
  );

  always #5 clk = ~clk;

  // Baud tick: one clock wide, every fourth clock.
  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // Record every delivered word as {parity_err, frame_err, data}.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (valid_a) q_a.push_back({perr_a, ferr_a, data_a});
      if (valid_b) q_b.push_back({perr_b, ferr_b, data_b});
      if (busy_b) busy_cyc_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Even-parity bit for a byte: 1 when the byte has an odd number of ones.
  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic set_line(input bit which, input logic v);
    if (which) rx_b = v;
    else rx_a = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit which, input logic v);
    set_line(which, v);
    idle(BIT_CLKS);
  endtask

  // A frames carry a parity bit and one stop bit; B frames carry two stop bits.
  task automatic send_frame(input bit which, input logic [7:0] d, input logic par,
                            input logic s1, input logic s2);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (!which) drive_bit(which, par);
    drive_bit(which, s1);
    if (which) drive_bit(which, s2);
    set_line(which, 1'b1);
  endtask

  task automatic expect_frame(input bit which, input string tag, input logic [7:0] d,
                              input logic pe, input logic fe);
    logic [9:0] got;
    got = 'x;
    if (which && q_b.size() > 0) got = q_b.pop_front();
    else if (!which && q_a.size() > 0) got = q_a.pop_front();
    check(tag, got, {pe, fe, d});
  endtask

  initial begin : stim
    logic [7:0] d;
    logic       bad_par, bad_stop, s1, s2;

    // Reset state
    idle(5);
    check("rst_data", data_a, 8'h00);
    check("rst_valid", valid_a, 1'b0);
    check("rst_perr", perr_a, 1'b0);
    check("rst_ferr", ferr_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    rst_n = 1'b1;
    idle(20);

    // No-parity frame on B, busy spans start detection to last stop-bit centre
    busy_cyc_b = 0;
    send_frame(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
    idle(40);
    check("a5_count", q_b.size(), 1);
    expect_frame(1'b1, "a5_frame", 8'hA5, 1'b0, 1'b0);
    check("a5_busy_len", (busy_cyc_b >= 664 && busy_cyc_b <= 680), 1'b1);
    check("a5_busy_end", busy_b, 1'b0);

    // Even parity on A: good then corrupted parity bit
    send_frame(1'b0, 8'h03, even_par(8'h03), 1'b1, 1'b1);
    idle(40);
    send_frame(1'b0, 8'h07, 1'b0, 1'b1, 1'b1);
    idle(40);
    check("par_count", q_a.size(), 2);
    expect_frame(1'b0, "par_ok", 8'h03, 1'b0, 1'b0);
    expect_frame(1'b0, "par_bad", 8'h07, 1'b1, 1'b0);
    check("par_held", perr_a, 1'b1);

    // Glitch shorter than half a bit
    rx_a = 1'b0;
    idle(16);
    check("glitch_busy", busy_a, 1'b1);
    rx_a = 1'b1;
    idle(BIT_CLKS);
    check("glitch_idle", busy_a, 1'b0);
    check("glitch_novalid", q_a.size(), 0);

    // Low stop bit then a held-low line: one frame with frame_err
    send_frame(1'b0, 8'h55, even_par(8'h55), 1'b0, 1'b1);
    rx_a = 1'b0;
    idle(3 * 11 * BIT_CLKS);
    check("brk_count", q_a.size(), 1);
    expect_frame(1'b0, "brk_frame", 8'h55, 1'b0, 1'b1);
    check("brk_busy", busy_a, 1'b1);
    rx_a = 1'b1;
    idle(40);
    check("brk_release", busy_a, 1'b0);
    send_frame(1'b0, 8'h3C, even_par(8'h3C), 1'b1, 1'b1);
    idle(40);
    check("after_brk_count", q_a.size(), 1);
    expect_frame(1'b0, "after_brk", 8'h3C, 1'b0, 1'b0);

    // Back-to-back frames on B with no idle gap
    send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    send_frame(1'b1, 8'h81, 1'b0, 1'b1, 1'b1);
    idle(40);
    check("b2b_count", q_b.size(), 3);
    expect_frame(1'b1, "b2b_0", 8'h00, 1'b0, 1'b0);
    expect_frame(1'b1, "b2b_1", 8'hFF, 1'b0, 1'b0);
    expect_frame(1'b1, "b2b_2", 8'h81, 1'b0, 1'b0);

    // Reset in the middle of data bit 4 of 0xC3
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 8'hC3 >> i);
    rx_a = 1'b0;  // bit 4 of 0xC3
    idle(BIT_CLKS / 2);
    rst_n = 1'b0;
    idle(4);
    check("mid_rst_data", data_a, 8'h00);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_valid", valid_a, 1'b0);
    check("mid_rst_ferr", ferr_a, 1'b0);
    rx_a = 1'b1;
    rst_n = 1'b1;
    idle(BIT_CLKS);
    check("mid_rst_novalid", q_a.size(), 0);
    send_frame(1'b0, 8'h12, even_par(8'h12), 1'b1, 1'b1);
    idle(40);
    check("post_rst_count", q_a.size(), 1);
    expect_frame(1'b0, "post_rst", 8'h12, 1'b0, 1'b0);

    // Random frames on A with occasional bad parity or stop bit
    for (int n = 0; n < 8; n++) begin
      d        = 8'($urandom);
      bad_par  = ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 4) == 0);
      send_frame(1'b0, d, even_par(d) ^ bad_par, ~bad_stop, 1'b1);
      idle(48);
      check("rnd_a_count", q_a.size(), 1);
      expect_frame(1'b0, "rnd_a", d, bad_par, bad_stop);
    end

    // Random frames on B with occasional low stop bits
    for (int n = 0; n < 8; n++) begin
      d  = 8'($urandom);
      s1 = ($urandom_range(0, 4) != 0);
      s2 = ($urandom_range(0, 4) != 0);
      send_frame(1'b1, d, 1'b0, s1, s2);
      idle(48);
      check("rnd_b_count", q_b.size(), 1);
      expect_frame(1'b1, "rnd_b", d, 1'b0, ~(s1 & s2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
